// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-lite encodings and the per-master request record used by
// the instruction-RAM arbiter (imem_arbiter, ahb_req_buf).
//   HTRANS_*  transfer type encodings
//   HSIZE_*   transfer size encodings
//   HRESP_*   response encodings
//   req_t     buffered request {addr, write, size}
//   lane_wben active-low byte-lane write enables for a size/offset pair
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } req_t;

  // Bit i low enables lane [8i+7:8i]. Misaligned halves/words still use the
  // lanes implied by haddr[1] (half) or all four lanes (word).
  function automatic logic [3:0] lane_wben(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: lane_wben = ~(4'b0001 << a);
      HSIZE_HALF: lane_wben = a[1] ? 4'b0011 : 4'b1100;
      HSIZE_WORD: lane_wben = 4'b0000;
      default:    lane_wben = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_req_buf.sv
// ahb_req_buf: per-master front end of imem_arbiter. Qualifies the live address
// phase, holds one request that lost arbitration, tracks the read data phase
// and generates hready/hresp/hrdata for its master.
// Optional feature: IMEM_ARB_ERR_EN adds alignment/range checking with a
// two-cycle ERROR response; without it hresp is always OKAY.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_haddr/i_hwrite/i_hsize/i_htrans   master address phase
//   i_grant                   arbiter grants o_req this cycle
//   i_ram_rdata               RAM read data (valid the cycle after the address)
//   o_live                    valid, error-free live address phase
//   o_bvld                    buffered request pending
//   o_req                     buffered request if pending, else the live one
//   o_hrdata/o_hready/o_hresp master response
module ahb_req_buf
  import ahb_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_haddr,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [1:0]  i_htrans,
  input  logic        i_grant,
  input  logic [31:0] i_ram_rdata,
  output logic        o_live,
  output logic        o_bvld,
  output req_t        o_req,
  output logic [31:0] o_hrdata,
  output logic        o_hready,
  output logic        o_hresp
);

  req_t r_buf;
  logic r_bvld, r_dp_rd, r_err1, r_err2;
  logic w_active, w_err, w_take;
  req_t w_live_req;

  always_comb begin
    w_active = 1'b0;
    case (i_htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: w_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  w_active = 1'b0;
      default:                   w_active = 1'b0;
    endcase
  end

`ifdef IMEM_ARB_ERR_EN
  logic [31:0] w_off;
  logic        w_mis, w_oor;
  assign w_off = i_haddr - BASE_ADDR;
  assign w_mis = ((i_hsize == HSIZE_HALF) && i_haddr[0]) ||
                 ((i_hsize == HSIZE_WORD) && (i_haddr[1:0] != 2'b00));
  assign w_oor = (i_haddr < BASE_ADDR) || ((w_off >> (ADDR_W + 2)) != 32'd0);
  assign w_err = w_mis || w_oor;
`else
  logic unused_cfg;
  assign unused_cfg = ^{BASE_ADDR, 32'(ADDR_W)};
  assign w_err = 1'b0;
`endif

  // Reset gates the live request so nothing is granted while reset is held.
  assign w_take     = i_rst_n && o_hready && w_active;
  assign w_live_req = '{addr: i_haddr, write: i_hwrite, size: i_hsize};

  assign o_live   = w_take && !w_err;
  assign o_bvld   = r_bvld;
  assign o_req    = r_bvld ? r_buf : w_live_req;
  assign o_hready = !r_bvld && !r_err1;
  assign o_hresp  = (r_err1 || r_err2) ? HRESP_ERROR : HRESP_OKAY;
  assign o_hrdata = r_dp_rd ? i_ram_rdata : 32'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf   <= '0;
      r_bvld  <= 1'b0;
      r_dp_rd <= 1'b0;
      r_err1  <= 1'b0;
      r_err2  <= 1'b0;
    end else begin
      r_dp_rd <= i_grant && !o_req.write;
      r_err1  <= w_take && w_err;
      r_err2  <= r_err1;
      if (r_bvld) begin
        if (i_grant) r_bvld <= 1'b0;
      end else if (o_live && !i_grant) begin
        r_bvld <= 1'b1;
        r_buf  <= w_live_req;
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one 32-bit instruction RAM (four byte-lane macros)
// between the SPI loader (spi_*) and the core fetch port (imem_*), both
// AHB-lite. Uncontested accesses run with zero wait states; conflicts are
// resolved round-robin, with the loser held in a one-entry buffer.
// Optional feature: IMEM_ARB_ERR_EN (alignment/window checks, in ahb_req_buf).
// Ports:
//   clk, reset                 clock, async active-low reset
//   spi_*/imem_*               AHB-lite slave ports (haddr, hwrite, hsize,
//                              htrans, hwdata in; hrdata, hready, hresp out)
//   ram_addr/ram_rwn/ram_wben/ram_wdata  RAM control (wben active low)
//   ram_rdata                  RAM read data, one cycle after the address
module imem_arbiter
  import ahb_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       spi_haddr,
  input  logic              spi_hwrite,
  input  logic [2:0]        spi_hsize,
  input  logic [1:0]        spi_htrans,
  input  logic [31:0]       spi_hwdata,
  output logic [31:0]       spi_hrdata,
  output logic              spi_hready,
  output logic              spi_hresp,
  input  logic [31:0]       imem_haddr,
  input  logic              imem_hwrite,
  input  logic [2:0]        imem_hsize,
  input  logic [1:0]        imem_htrans,
  input  logic [31:0]       imem_hwdata,
  output logic [31:0]       imem_hrdata,
  output logic              imem_hready,
  output logic              imem_hresp,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rwn,
  output logic [3:0]        ram_wben,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic w_s_live, w_s_bvld, w_i_live, w_i_bvld;
  req_t w_s_req, w_i_req, w_g_req;
  logic w_gnt_s, w_gnt_i, w_any, w_tie;

  logic              r_rr;        // 0: spi wins next tie, 1: imem
  logic              r_wdp;       // write data phase owns the RAM this cycle
  logic              r_wdp_imem;
  logic [3:0]        r_wdp_wben;
  logic [ADDR_W-1:0] r_wdp_addr;

  ahb_req_buf #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_spi (
    .i_clk(clk), .i_rst_n(reset),
    .i_haddr(spi_haddr), .i_hwrite(spi_hwrite), .i_hsize(spi_hsize), .i_htrans(spi_htrans),
    .i_grant(w_gnt_s), .i_ram_rdata(ram_rdata),
    .o_live(w_s_live), .o_bvld(w_s_bvld), .o_req(w_s_req),
    .o_hrdata(spi_hrdata), .o_hready(spi_hready), .o_hresp(spi_hresp)
  );

  ahb_req_buf #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_imem (
    .i_clk(clk), .i_rst_n(reset),
    .i_haddr(imem_haddr), .i_hwrite(imem_hwrite), .i_hsize(imem_hsize), .i_htrans(imem_htrans),
    .i_grant(w_gnt_i), .i_ram_rdata(ram_rdata),
    .o_live(w_i_live), .o_bvld(w_i_bvld), .o_req(w_i_req),
    .o_hrdata(imem_hrdata), .o_hready(imem_hready), .o_hresp(imem_hresp)
  );

  // Ownership: write data phase > buffered request > live address phase.
  // A write's grant reserves the following cycle, so nothing else is granted
  // while r_wdp is set; a request arriving then is buffered.
  always_comb begin
    w_gnt_s = 1'b0;
    w_gnt_i = 1'b0;
    w_tie   = 1'b0;
    if (!r_wdp) begin
      if (w_s_bvld && w_i_bvld) begin
        w_tie   = 1'b1;
        w_gnt_i = r_rr;
        w_gnt_s = !r_rr;
      end else if (w_s_bvld) begin
        w_gnt_s = 1'b1;
      end else if (w_i_bvld) begin
        w_gnt_i = 1'b1;
      end else if (w_s_live && w_i_live) begin
        w_tie   = 1'b1;
        w_gnt_i = r_rr;
        w_gnt_s = !r_rr;
      end else if (w_s_live) begin
        w_gnt_s = 1'b1;
      end else if (w_i_live) begin
        w_gnt_i = 1'b1;
      end
    end
  end

  assign w_any   = w_gnt_s || w_gnt_i;
  assign w_g_req = w_gnt_i ? w_i_req : w_s_req;

  logic unused_hi;
  assign unused_hi = ^w_g_req.addr[31:ADDR_W+2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr       <= 1'b0;
      r_wdp      <= 1'b0;
      r_wdp_imem <= 1'b0;
      r_wdp_wben <= 4'hF;
      r_wdp_addr <= '0;
    end else begin
      // Pointer moves to the loser, so it only changes on a tie.
      if (w_tie) r_rr <= w_gnt_s;
      r_wdp <= w_any && w_g_req.write;
      if (w_any && w_g_req.write) begin
        r_wdp_imem <= w_gnt_i;
        r_wdp_wben <= lane_wben(w_g_req.size, w_g_req.addr[1:0]);
        r_wdp_addr <= w_g_req.addr[ADDR_W+1:2];
      end
    end
  end

  // Reads address the RAM in their grant cycle; writes in the cycle after.
  always_comb begin
    ram_addr  = '0;
    ram_rwn   = 1'b1;
    ram_wben  = 4'hF;
    ram_wdata = 32'd0;
    if (r_wdp) begin
      ram_addr  = r_wdp_addr;
      ram_rwn   = 1'b0;
      ram_wben  = r_wdp_wben;
      ram_wdata = r_wdp_imem ? imem_hwdata : spi_hwdata;
    end else if (w_any) begin
      ram_addr  = w_g_req.addr[ADDR_W+1:2];
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  localparam int ADDR_W = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] spi_haddr, spi_hwdata, spi_hrdata;
  logic        spi_hwrite, spi_hready, spi_hresp;
  logic [2:0]  spi_hsize;
  logic [1:0]  spi_htrans;
  logic [31:0] imem_haddr, imem_hwdata, imem_hrdata;
  logic        imem_hwrite, imem_hready, imem_hresp;
  logic [2:0]  imem_hsize;
  logic [1:0]  imem_htrans;
  logic [ADDR_W-1:0] ram_addr;
  logic        ram_rwn;
  logic [3:0]  ram_wben;
  logic [31:0] ram_wdata, ram_rdata;

  imem_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .spi_haddr(spi_haddr), .spi_hwrite(spi_hwrite), .spi_hsize(spi_hsize),
    .spi_htrans(spi_htrans), .spi_hwdata(spi_hwdata), .spi_hrdata(spi_hrdata),
    .spi_hready(spi_hready), .spi_hresp(spi_hresp),
    .imem_haddr(imem_haddr), .imem_hwrite(imem_hwrite), .imem_hsize(imem_hsize),
    .imem_htrans(imem_htrans), .imem_hwdata(imem_hwdata), .imem_hrdata(imem_hrdata),
    .imem_hready(imem_hready), .imem_hresp(imem_hresp),
    .ram_addr(ram_addr), .ram_rwn(ram_rwn), .ram_wben(ram_wben),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'h5A00_0000 | (i * 32'h0001_0101);
  endfunction

  // Synchronous RAM model with byte lanes.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);
  always @(posedge clk) begin
    if (!ram_rwn)
      for (int b = 0; b < 4; b++)
        if (!ram_wben[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr[7:0]];
  end

  // Shadow of RAM contents as the bench expects them.
  logic [31:0] sh [0:255];
  initial for (int i = 0; i < 256; i++) sh[i] = init_word(i);

  int ncmp = 0, nerr = 0;
  logic [31:0] q_spi[$], q_imem[$];
  logic s_pend = 1'b0, i_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sh_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int w;
    w = int'(a[9:2]);
    for (int b = 0; b < 4; b++) begin
      logic en;
      en = (sz == 3'd0) ? (b == int'(a[1:0])) :
           (sz == 3'd1) ? ((b / 2) == int'(a[1])) : 1'b1;
      if (en) sh[w][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Mid-cycle bus monitor: completes read data phases against the scoreboard.
  task automatic mon();
    @(negedge clk);
    if (spi_hready) begin
      if (s_pend && !spi_hresp) begin
        if (q_spi.size() == 0) begin
          ncmp++; nerr++;
          $error("FAIL spi_sb: observed data phase %h, expected no transfer", spi_hrdata);
        end else chk("spi_hrdata", spi_hrdata, q_spi.pop_front());
      end
      s_pend = spi_htrans[1] && !spi_hwrite;
    end
    if (imem_hready) begin
      if (i_pend && !imem_hresp) begin
        if (q_imem.size() == 0) begin
          ncmp++; nerr++;
          $error("FAIL imem_sb: observed data phase %h, expected no transfer", imem_hrdata);
        end else chk("imem_hrdata", imem_hrdata, q_imem.pop_front());
      end
      i_pend = imem_htrans[1] && !imem_hwrite;
    end
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    spi_htrans = 2'd0; spi_hwrite = 1'b0;
    imem_htrans = 2'd0; imem_hwrite = 1'b0;
  endtask

  task automatic drv_spi(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    spi_htrans = 2'd2; spi_hwrite = wr; spi_hsize = sz; spi_haddr = a;
    if (!wr) q_spi.push_back(sh[a[9:2]]);
  endtask

  task automatic drv_imem(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    imem_htrans = 2'd2; imem_hwrite = wr; imem_hsize = sz; imem_haddr = a;
    if (!wr) q_imem.push_back(sh[a[9:2]]);
  endtask

  initial begin
    reset = 1'b0;
    spi_haddr = '0; spi_hsize = 3'd2; spi_hwdata = '0;
    imem_haddr = '0; imem_hsize = 3'd2; imem_hwdata = '0;
    idle_all();
    adv();
    mon();
    chk("rst_spi_hready", 32'(spi_hready), 1);
    chk("rst_imem_hready", 32'(imem_hready), 1);
    chk("rst_hresp", {30'd0, spi_hresp, imem_hresp}, 0);
    chk("rst_spi_hrdata", spi_hrdata, 0);
    chk("rst_imem_hrdata", imem_hrdata, 0);
    chk("rst_ram_rwn", 32'(ram_rwn), 1);
    chk("rst_ram_wben", 32'(ram_wben), 32'hF);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    adv();
    reset = 1'b1;
    mon(); adv();

    // Uncontested imem read of word 4.
    drv_imem(1'b0, 3'd2, 32'h10);
    mon(); chk("rd_addr", 32'(ram_addr), 4); chk("rd_rwn", 32'(ram_rwn), 1); adv();
    idle_all();
    mon(); chk("rd_hready", 32'(imem_hready), 1); adv();

    // spi byte write to 0x7.
    drv_spi(1'b1, 3'd0, 32'h7);
    mon(); adv();
    idle_all(); spi_hwdata = 32'hAB00_0000; sh_write(32'h7, 3'd0, spi_hwdata);
    mon();
    chk("bw_rwn", 32'(ram_rwn), 0); chk("bw_wben", 32'(ram_wben), 32'h7);
    chk("bw_wdata", ram_wdata, 32'hAB00_0000); chk("bw_addr", 32'(ram_addr), 1);
    chk("bw_hready", 32'(spi_hready), 1);
    adv();

    // Simultaneous reads, pointer at spi.
    drv_spi(1'b0, 3'd2, 32'h0); drv_imem(1'b0, 3'd2, 32'h4);
    mon(); chk("rr1_addr_spi", 32'(ram_addr), 0); adv();
    idle_all();
    mon(); chk("rr1_imem_wait", 32'(imem_hready), 0); chk("rr1_addr_imem", 32'(ram_addr), 1); adv();
    mon(); adv();

    // Reset during an imem write data phase with a buffered spi read (pointer at imem).
    drv_spi(1'b0, 3'd2, 32'h0); q_spi.delete(); drv_imem(1'b1, 3'd2, 32'h20);
    mon(); chk("rs_wr_gnt_rwn", 32'(ram_rwn), 1); adv();
    reset = 1'b0; idle_all(); imem_hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rs_spi_hready", 32'(spi_hready), 1); chk("rs_imem_hready", 32'(imem_hready), 1);
    chk("rs_rwn", 32'(ram_rwn), 1); chk("rs_wben", 32'(ram_wben), 32'hF);
    chk("rs_addr", 32'(ram_addr), 0); chk("rs_spi_hrdata", spi_hrdata, 0);
    s_pend = 1'b0; i_pend = 1'b0; q_spi.delete(); q_imem.delete();
    adv();
    reset = 1'b1;
    mon(); chk("rs_buf_empty", 32'(spi_hready), 1); chk("rs_no_wr", 32'(ram_rwn), 1); adv();

    // Pointer back at spi after reset; word 8 must hold its old value.
    drv_spi(1'b0, 3'd2, 32'h20); drv_imem(1'b0, 3'd2, 32'h0);
    mon(); chk("rr2_addr_spi", 32'(ram_addr), 8); adv();
    idle_all();
    mon(); chk("rr2_addr_imem", 32'(ram_addr), 0); adv();
    mon(); adv();

    // Pointer now at imem.
    drv_spi(1'b0, 3'd2, 32'hC); drv_imem(1'b0, 3'd2, 32'h10);
    mon(); chk("rr3_addr_imem", 32'(ram_addr), 4); adv();
    idle_all();
    mon(); chk("rr3_spi_wait", 32'(spi_hready), 0); chk("rr3_addr_spi", 32'(ram_addr), 3); adv();
    mon(); adv();

    // spi word write 0x8 then imem read 0x8.
    drv_spi(1'b1, 3'd2, 32'h8);
    mon(); adv();
    spi_htrans = 2'd0; spi_hwdata = 32'h1234_5678; sh_write(32'h8, 3'd2, spi_hwdata);
    drv_imem(1'b0, 3'd2, 32'h8);
    mon();
    chk("wr_rwn", 32'(ram_rwn), 0); chk("wr_wben", 32'(ram_wben), 0);
    chk("wr_addr", 32'(ram_addr), 2); chk("wr_wdata", ram_wdata, 32'h1234_5678);
    adv();
    idle_all();
    mon(); chk("wr_rd_wait", 32'(imem_hready), 0); chk("wr_rd_addr", 32'(ram_addr), 2);
    chk("wr_rd_rwn", 32'(ram_rwn), 1); adv();
    mon(); chk("wr_rd_hready", 32'(imem_hready), 1); adv();

    // imem half write 0x16 then read of the same word by imem.
    drv_imem(1'b1, 3'd1, 32'h16);
    mon(); adv();
    imem_hwdata = 32'hCAFE_0000; sh_write(32'h16, 3'd1, imem_hwdata);
    drv_imem(1'b0, 3'd2, 32'h14);
    mon(); chk("hw_wben", 32'(ram_wben), 32'h3); chk("hw_rwn", 32'(ram_rwn), 0);
    chk("hw_addr", 32'(ram_addr), 5); adv();
    idle_all();
    mon(); chk("hw_rd_wait", 32'(imem_hready), 0); chk("hw_rd_addr", 32'(ram_addr), 5); adv();
    mon(); adv();

`ifdef IMEM_ARB_ERR_EN
    drv_imem(1'b0, 3'd2, 32'h2); q_imem.delete();
    mon(); chk("err_rwn", 32'(ram_rwn), 1); chk("err_addr", 32'(ram_addr), 0); adv();
    idle_all();
    mon(); chk("err1_hready", 32'(imem_hready), 0); chk("err1_hresp", 32'(imem_hresp), 1); adv();
    mon(); chk("err2_hready", 32'(imem_hready), 1); chk("err2_hresp", 32'(imem_hresp), 1); adv();
    drv_spi(1'b0, 3'd2, 32'h0001_0000); q_spi.delete();
    mon(); chk("oor_rwn", 32'(ram_rwn), 1); chk("err_done", 32'(imem_hresp), 0); adv();
    idle_all();
    mon(); chk("oor_hresp", 32'(spi_hresp), 1); chk("oor_hready", 32'(spi_hready), 0); adv();
    mon(); adv();
`else
    // Upper address bits wrap onto the RAM window.
    drv_spi(1'b0, 3'd2, 32'h0001_0010);
    mon(); chk("wrap_addr", 32'(ram_addr), 4); adv();
    idle_all();
    mon(); chk("wrap_hresp", 32'(spi_hresp), 0); adv();
`endif

    mon();
    chk("spi_sb_left", 32'(q_spi.size()), 0);
    chk("imem_sb_left", 32'(q_imem.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
